pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register (IF->ID and later stages) with valid/ready handshake.

---
 rtl/pipe_stage_reg.sv | 215 +++++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose
//   Inter-stage pipeline register that carries one instruction word and its PC
//   between two pipeline stages (IF->ID and later). It holds up to two entries:
//   a main slot, which is always the head, and a skid slot. Because of the skid
//   slot, in_ready is decoded from state only and has no combinational path
//   from out_ready. The block also provides freeze (stall), flush with NOP bubble
//   injection, and optional occupancy/stall statistics.
//
// Handshake
//   A transfer happens on a side only in a cycle where both valid and ready are
//   high at the rising clock edge. A producer must hold valid and its payload
//   stable until that transfer happens. Ready never depends on valid from the
//   same side. in_ready also never depends on out_ready.
//
// Configuration
//   PIPE_STATS_EN  When this macro is defined, the saturating stall_cnt and
//                  flush_cnt counters are built. When it is undefined, both
//                  outputs are tied to zero and no counter logic exists.
//
// Ports
//   clk        in   1        clock; all state updates on posedge
//   rst        in   1        synchronous reset, active-low
//   freeze     in   1        stall: no transfer on either side while high
//   flush      in   FLUSH_W  any nonzero bit discards all held entries
//   in_valid   in   1        upstream entry valid
//   in_ready   out  1        register can accept this cycle
//   in_inst    in   INST_W   upstream instruction
//   in_pc      in   PC_W     upstream PC
//   out_valid  out  1        out_inst/out_pc valid
//   out_ready  in   1        downstream accepts
//   out_inst   out  INST_W   head instruction (NOP_INST when empty)
//   out_pc     out  PC_W     head PC (0 when empty)
//   stall_cnt  out  CNT_W    cycles with in_valid & ~in_ready
//   flush_cnt  out  CNT_W    cycles with flush asserted
//   dbg_state  out  2        FSM state (0 EMPTY, 1 ONE, 2 TWO)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned         INST_W   = 32,
  parameter int unsigned         PC_W     = 32,
  parameter int unsigned         FLUSH_W  = 2,
  parameter logic [INST_W-1:0]   NOP_INST = 32'hFC000000,
  parameter int unsigned         CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic [FLUSH_W-1:0] flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INST_W-1:0]  in_inst,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INST_W-1:0]  out_inst,
  output logic [PC_W-1:0]    out_pc,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [INST_W-1:0]   r_main_inst;
  logic [PC_W-1:0]     r_main_pc;
  logic [INST_W-1:0]   r_skid_inst;
  logic [PC_W-1:0]     r_skid_pc;

  logic                w_fl;
  logic                w_in_fire;
  logic                w_out_fire;
  logic                w_load_main_in;
  logic                w_load_main_skid;
  logic                w_load_skid;

  // ---------------------------------------------------------------------------
  // Handshake decode. Flush masks in_ready, so an entry offered in the flush
  // cycle is never accepted. Freeze masks both sides, so nothing moves.
  // ---------------------------------------------------------------------------
  assign w_fl       = |flush;
  assign in_ready   = (r_state != ST_TWO) & ~freeze & ~w_fl;
  assign out_valid  = (r_state != ST_EMPTY) & ~freeze;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // Empty register shows a NOP bubble and PC 0, never stale data.
  assign out_inst  = (r_state == ST_EMPTY) ? NOP_INST : r_main_inst;
  assign out_pc    = (r_state == ST_EMPTY) ? '0       : r_main_pc;
  assign dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and slot load enables
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;

    if (w_fl) begin
      // Flush wins over freeze and any handshake and drops both slots.
      w_state_nxt = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt    = ST_ONE;
            w_load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            // The head leaves and the new entry takes its place.
            w_load_main_in = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = ST_TWO;
            w_load_skid = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            w_state_nxt      = ST_ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Payload slots
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_main_inst <= NOP_INST;
      r_main_pc   <= '0;
    end else if (w_load_main_in) begin
      r_main_inst <= in_inst;
      r_main_pc   <= in_pc;
    end else if (w_load_main_skid) begin
      r_main_inst <= r_skid_inst;
      r_main_pc   <= r_skid_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_skid_inst <= NOP_INST;
      r_skid_pc   <= '0;
    end else if (w_load_skid) begin
      r_skid_inst <= in_inst;
      r_skid_pc   <= in_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall;

  assign w_stall = in_valid & ~in_ready;

  // Both counters stop at all-ones and do not wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_flush_cnt <= '0;
    end else if (w_fl && !(&r_flush_cnt)) begin
      r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg. The counters are built with width 4 so
// that saturation is reachable. Statistic expectations are zero when
// PIPE_STATS_EN is undefined. A negedge scoreboard records every accepted
// entry in exp_q and checks that delivered entries come out in FIFO order.
// Flush and reset empty exp_q, because the DUT drops held entries in both cases.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned FLUSH_W = 2;
  localparam int unsigned CNT_W   = 4;
  localparam logic [31:0] NOP     = 32'hFC000000;
`ifdef PIPE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic               clk = 1'b0;
  logic               rst;
  logic               freeze;
  logic [FLUSH_W-1:0] flush;
  logic               in_valid;
  logic               in_ready;
  logic [INST_W-1:0]  in_inst;
  logic [PC_W-1:0]    in_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INST_W-1:0]  out_inst;
  logic [PC_W-1:0]    out_pc;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;
  logic [1:0]         dbg_state;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .INST_W  (INST_W),
    .PC_W    (PC_W),
    .FLUSH_W (FLUSH_W),
    .NOP_INST(NOP),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .freeze   (freeze),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_inst  (in_inst),
    .in_pc    (in_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst (out_inst),
    .out_pc   (out_pc),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int checks    = 0;
  int errors    = 0;
  int delivered = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] stat(input int v);
    return STATS ? 64'(v) : 64'd0;
  endfunction

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard: {inst, pc} of every accepted entry, in order
  // ---------------------------------------------------------------------------
  logic [63:0] exp_q[$];
  logic [63:0] exp_w;

  always @(negedge clk) begin
    if (!rst || (|flush)) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("q_nonempty_on_out", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check("order_inst", 64'(out_inst), 64'(exp_w[63:32]));
          check("order_pc",   64'(out_pc),   64'(exp_w[31:0]));
          delivered++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back({in_inst, in_pc});
    end
  end

  // Time bound in case the sequence stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b0; freeze = 1'b0; flush = '0; in_valid = 1'b0;
    in_inst = '0; in_pc = '0; out_ready = 1'b0;

    // 1 Reset
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_inst",  64'(out_inst),  64'(NOP));
    check("rst_out_pc",    64'(out_pc),    64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_state",     64'(dbg_state), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
    rst = 1'b1;

    // 2 Stream A0..A9, one per cycle, 1-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_inst  = 32'hA000_0000 + 32'(i);
      in_pc    = 32'(i * 4);
      #1;
      check("stream_in_ready", 64'(in_ready), 64'd1);
      tick();
      check("stream_out_valid", 64'(out_valid), 64'd1);
      check("stream_out_inst",  64'(out_inst),  64'(32'hA000_0000 + 32'(i)));
      check("stream_out_pc",    64'(out_pc),    64'(i * 4));
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_valid", 64'(out_valid), 64'd0);
    check("stream_end_inst",  64'(out_inst),  64'(NOP));
    check("stream_end_pc",    64'(out_pc),    64'd0);

    // 3 Backpressure: X, Y fill both slots, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hC0DE_0001; in_pc = 32'd100;
    tick();
    check("bp_one_state", 64'(dbg_state), 64'd1);
    check("bp_one_inst",  64'(out_inst),  64'h0000_0000_C0DE_0001);
    in_inst = 32'hC0DE_0002; in_pc = 32'd104;
    #1;
    check("bp_one_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    check("bp_two_in_ready", 64'(in_ready),  64'd0);
    check("bp_two_state",    64'(dbg_state), 64'd2);
    check("bp_two_inst",     64'(out_inst),  64'h0000_0000_C0DE_0001);
    check("bp_two_pc",       64'(out_pc),    64'd100);
    out_ready = 1'b1;
    tick();
    check("bp_drain_y_inst", 64'(out_inst),  64'h0000_0000_C0DE_0002);
    check("bp_drain_y_pc",   64'(out_pc),    64'd104);
    check("bp_drain_state",  64'(dbg_state), 64'd1);
    tick();
    check("bp_empty_valid",  64'(out_valid), 64'd0);

    // 4 Flush while TWO
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hDEAD_0001; in_pc = 32'd200;
    tick();
    in_inst = 32'hDEAD_0002; in_pc = 32'd204;
    tick();
    in_valid = 1'b0; flush = 2'b01;
    #1;
    check("fl_in_ready",  64'(in_ready),  64'd0);
    check("fl_pre_state", 64'(dbg_state), 64'd2);
    tick();
    flush = '0;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_out_inst",  64'(out_inst),  64'(NOP));
    check("fl_out_pc",    64'(out_pc),    64'd0);
    check("fl_state",     64'(dbg_state), 64'd0);
    check("fl_flush_cnt", 64'(flush_cnt), stat(1));
    check("fl_stall_cnt", 64'(stall_cnt), stat(0));
    #1;
    check("fl_after_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) tick();
    check("fl_no_resurrect", 64'(out_valid), 64'd0);

    // 5 Freeze with flush, then freeze alone
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    check("rst2_flush_cnt", 64'(flush_cnt), 64'd0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hBEEF_0001; in_pc = 32'd300;
    tick();
    check("fz_z_inst", 64'(out_inst), 64'h0000_0000_BEEF_0001);
    in_valid = 1'b0; freeze = 1'b1; flush = 2'b10;
    #1;
    check("fz_fl_out_valid", 64'(out_valid), 64'd0);
    check("fz_fl_in_ready",  64'(in_ready),  64'd0);
    tick();
    flush = '0;
    check("fz_fl_state",     64'(dbg_state), 64'd0);
    check("fz_fl_inst",      64'(out_inst),  64'(NOP));
    check("fz_fl_pc",        64'(out_pc),    64'd0);
    check("fz_fl_flush_cnt", 64'(flush_cnt), stat(1));
    freeze = 1'b0;
    in_valid = 1'b1; in_inst = 32'hBEEF_0002; in_pc = 32'd304;
    tick();
    check("fz_w_inst", 64'(out_inst), 64'h0000_0000_BEEF_0002);
    freeze = 1'b1; out_ready = 1'b1;
    in_inst = 32'hBEEF_0003; in_pc = 32'd308;
    #1;
    check("fz_in_ready",  64'(in_ready),  64'd0);
    check("fz_out_valid", 64'(out_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fz_hold_inst",  64'(out_inst),  64'h0000_0000_BEEF_0002);
      check("fz_hold_pc",    64'(out_pc),    64'd304);
      check("fz_hold_state", 64'(dbg_state), 64'd1);
    end
    check("fz_stall_cnt", 64'(stall_cnt), stat(3));
    freeze = 1'b0; in_valid = 1'b0;
    tick();
    check("fz_release_valid", 64'(out_valid), 64'd0);
    check("fz_release_stall", 64'(stall_cnt), stat(3));

    // 6 Stall counter saturation
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h5A5A_0000; in_pc = 32'd400;
    tick();
    in_inst = 32'h5A5A_0001; in_pc = 32'd404;
    tick();
    in_inst = 32'h5A5A_0002; in_pc = 32'd408;
    check("sat_start", 64'(stall_cnt), stat(0));
    repeat (14) tick();
    check("sat_14", 64'(stall_cnt), stat(14));
    tick();
    check("sat_15", 64'(stall_cnt), stat(15));
    repeat (5) tick();
    check("sat_20", 64'(stall_cnt), stat(15));
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("sat_drain_inst", 64'(out_inst), 64'h0000_0000_5A5A_0001);
    check("sat_drain_pc",   64'(out_pc),   64'd404);
    tick();
    check("sat_empty_valid", 64'(out_valid), 64'd0);
    check("sat_hold",        64'(stall_cnt), stat(15));

    // End of run: everything accepted and not flushed came out exactly once.
    #1;
    check("final_q_empty",  64'(exp_q.size()), 64'd0);
    check("final_delivered", 64'(delivered),   64'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
